demux_deser4: RTL

DEMUX_DESER4 -- requirements
Module: demux_deser4

---
 rtl/demux_pkg.sv | 13 +
 rtl/rr_arb4.sv | 36 +++
 rtl/demux_deser4.sv | 124 ++++++++++++
 3 files changed

// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared constants for the 1:4 demux deserializer
//
// Purpose: channel count, channel-id width and the default word width used by
//          demux_deser4 and its round-robin arbiter.
// Ports:   none (package).

package demux_pkg;

  localparam int NUM_CH     = 4;
  localparam int CH_W       = 2;
  localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/rr_arb4.sv
// rtl/rr_arb4.sv - combinational 4-way round-robin arbiter
//
// Purpose: picks the first requesting channel in the order last+1, last+2,
//          last+3, last+4 (mod 4). Holds no state; the caller keeps 'last'.
// Ports:
//   req       in   NUM_CH  request per channel
//   last      in   CH_W    previously granted channel
//   gnt_valid out  1       some channel is requesting
//   gnt_id    out  CH_W    granted channel (equals last when gnt_valid=0)

module rr_arb4
  import demux_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   last,
  output logic              gnt_valid,
  output logic [CH_W-1:0]   gnt_id
);

  always_comb begin
    logic [CH_W-1:0] cand;
    gnt_valid = 1'b0;
    gnt_id    = last;
    cand      = last;
    // Walk from the farthest candidate to the nearest so the nearest
    // requester after 'last' overwrites and wins.
    for (int i = NUM_CH; i >= 1; i--) begin
      cand = last + CH_W'(i);
      if (req[cand]) begin
        gnt_valid = 1'b1;
        gnt_id    = cand;
      end
    end
  end

endmodule

// File: rtl/demux_deser4.sv
// rtl/demux_deser4.sv - per-channel deserializer behind a 1:4 bit demux
//
// Purpose: collects the bit stream demultiplexed onto y0..y3 (channel chosen by
//          sel) into one DATA_W word per channel, MSB first, and hands finished
//          words out through a single valid/ready output register, granting
//          channels round-robin. Bits arriving for a channel whose finished
//          word has not yet been taken are dropped and flagged in ovf.
// Ports:
//   clk        in   1       clock, rising edge
//   rst        in   1       asynchronous active-high reset
//   sel        in   CH_W    channel select of the demux
//   y0..y3     in   1       demux outputs; channel k bit is yk while sel==k
//   bit_valid  in   1       one bit transfer this cycle
//   out_data   out  DATA_W  assembled word
//   out_ch     out  CH_W    source channel of out_data
//   out_valid  out  1       out_data/out_ch valid
//   out_ready  in   1       downstream accept
//   ovf        out  NUM_CH  sticky per-channel overflow flags

module demux_deser4
  import demux_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CH_W-1:0]   sel,
  input  logic              y0,
  input  logic              y1,
  input  logic              y2,
  input  logic              y3,
  input  logic              bit_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NUM_CH-1:0] ovf
);

  localparam int              CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic [DATA_W-1:0] sr  [NUM_CH];
  logic [CNT_W-1:0]  cnt [NUM_CH];
  logic [NUM_CH-1:0] full;
  logic [CH_W-1:0]   last;

  logic [NUM_CH-1:0] yv;
  logic              bit_in;
  logic              accept;
  logic              drop;
  logic              out_free;
  logic              gnt_valid;
  logic [CH_W-1:0]   gnt_id;
  logic              take;

  assign yv     = {y3, y2, y1, y0};
  assign bit_in = yv[sel];

  // Both use the pre-edge full flag, so a channel being granted this edge
  // still rejects (and flags) a bit arriving on the same edge.
  assign accept = bit_valid & ~full[sel];
  assign drop   = bit_valid &  full[sel];

  assign out_free = ~out_valid | out_ready;
  assign take     = out_free & gnt_valid;

  rr_arb4 u_arb (
    .req       (full),
    .last      (last),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // Channel state. An accepting channel has full=0 and a granted channel has
  // full=1, so the set and clear of full below never target the same bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        sr[c]  <= '0;
        cnt[c] <= '0;
      end
      full <= '0;
      ovf  <= '0;
      last <= CH_W'(NUM_CH - 1);
    end else begin
      if (accept) begin
        sr[sel] <= {sr[sel][DATA_W-2:0], bit_in};
        if (cnt[sel] == CNT_LAST) begin
          cnt[sel]  <= '0;
          full[sel] <= 1'b1;
        end else begin
          cnt[sel] <= cnt[sel] + 1'b1;
        end
      end
      if (drop) begin
        ovf[sel] <= 1'b1;
      end
      if (take) begin
        full[gnt_id] <= 1'b0;
        last         <= gnt_id;
      end
    end
  end

  // Output register: data/channel only move when a new word is loaded, so
  // they hold steady while the downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
    end else if (out_free) begin
      if (gnt_valid) begin
        out_data  <= sr[gnt_id];
        out_ch    <= gnt_id;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
